// File: rtl/recovery_ctrl_if.sv
// Retire-side bundle between the ROB/retire stage and the mispredict recovery controller.
// Carries slot info in, plus commit, flush, redirect and predictor-training results out.
interface recovery_ctrl_if #(
  parameter int XLEN = 32
);
  logic [2:0]            retire_valid;
  logic [2:0]            retire_precise_need;
  logic [2:0][XLEN-1:0]  retire_pc;
  logic [2:0][XLEN-1:0]  retire_target_pc;
  logic [2:0]            retire_is_branch;
  logic [2:0]            retire_taken;
  logic                  sq_empty;
  logic                  fu_busy;

  logic [2:0]            commit_mask;
  logic                  recover_en;
  logic                  dispatch_stall;
  logic                  fetch_redirect_en;
  logic [XLEN-1:0]       fetch_redirect_pc;
  logic                  bp_update_en;
  logic [XLEN-1:0]       bp_update_pc;
  logic                  bp_update_dir;
  logic [XLEN-1:0]       bp_update_target;

  modport master (
    output retire_valid, retire_precise_need, retire_pc, retire_target_pc,
           retire_is_branch, retire_taken, sq_empty, fu_busy,
    input  commit_mask, recover_en, dispatch_stall, fetch_redirect_en,
           fetch_redirect_pc, bp_update_en, bp_update_pc, bp_update_dir, bp_update_target
  );

  modport slave (
    input  retire_valid, retire_precise_need, retire_pc, retire_target_pc,
           retire_is_branch, retire_taken, sq_empty, fu_busy,
    output commit_mask, recover_en, dispatch_stall, fetch_redirect_en,
           fetch_redirect_pc, bp_update_en, bp_update_pc, bp_update_dir, bp_update_target
  );
endinterface

// File: rtl/recovery_ctrl.sv
// Precise-state mispredict recovery: commit masking, FLUSH -> DRAIN -> REDIRECT, predictor training.
// Latency: recover_en at N+1, redirect earliest N+3, bp_update at N+1; no backpressure beyond dispatch_stall. Option: RECOVERY_STATS_EN.
module recovery_ctrl #(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 15
) (
  input  logic            clock,
  input  logic            reset,
  recovery_ctrl_if.slave  bus
`ifdef RECOVERY_STATS_EN
  ,
  output logic [15:0]     mispredict_count
`endif
);

  localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    DRAIN    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     drain_cnt_q, drain_cnt_d, drain_inc;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  logic              mis_hit;
  logic [1:0]        mis_slot;
  logic [2:0]        idle_mask;
  logic [2:0]        commit_mask;
  logic              recover_en, dispatch_stall, redirect_en;

  logic [2:0]        br_mask;
  logic              br_hit;
  logic [1:0]        br_slot;
  logic              bp_en_q, bp_dir_q;
  logic [XLEN-1:0]   bp_pc_q, bp_target_q, bp_target_d;

  // Oldest valid slot needing precise state bounds the commit; younger slots are squashed.
  always_comb begin
    mis_hit   = 1'b0;
    mis_slot  = 2'd0;
    idle_mask = bus.retire_valid;
    if (bus.retire_valid[2] && bus.retire_precise_need[2]) begin
      mis_hit   = 1'b1;
      mis_slot  = 2'd2;
      idle_mask = 3'b100;
    end else if (bus.retire_valid[1] && bus.retire_precise_need[1]) begin
      mis_hit   = 1'b1;
      mis_slot  = 2'd1;
      idle_mask = bus.retire_valid & 3'b110;
    end else if (bus.retire_valid[0] && bus.retire_precise_need[0]) begin
      mis_hit   = 1'b1;
      mis_slot  = 2'd0;
      idle_mask = bus.retire_valid;
    end
  end

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    redirect_pc_d  = redirect_pc_q;
    commit_mask    = 3'b000;
    recover_en     = 1'b0;
    dispatch_stall = 1'b0;
    redirect_en    = 1'b0;
    drain_inc      = (drain_cnt_q == CW'(DRAIN_MAX)) ? drain_cnt_q : drain_cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        commit_mask = idle_mask;
        if (mis_hit) begin
          redirect_pc_d = bus.retire_target_pc[mis_slot];
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        recover_en     = 1'b1;
        dispatch_stall = 1'b1;
        drain_cnt_d    = '0;
        state_d        = DRAIN;
      end
      DRAIN: begin
        dispatch_stall = 1'b1;
        drain_cnt_d    = drain_inc;
        // Timeout compares the post-increment count so DRAIN lasts at most DRAIN_MAX cycles.
        if ((bus.sq_empty && !bus.fu_busy) || (drain_inc == CW'(DRAIN_MAX))) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_en    = 1'b1;
        dispatch_stall = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      drain_cnt_q   <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Only the oldest committed branch trains the predictor.
  always_comb begin
    br_mask = commit_mask & bus.retire_is_branch;
    br_hit  = |br_mask;
    if (br_mask[2])      br_slot = 2'd2;
    else if (br_mask[1]) br_slot = 2'd1;
    else                 br_slot = 2'd0;
    bp_target_d = bus.retire_taken[br_slot] ? bus.retire_target_pc[br_slot]
                                            : bus.retire_pc[br_slot] + XLEN'(4);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bp_en_q     <= 1'b0;
      bp_dir_q    <= 1'b0;
      bp_pc_q     <= '0;
      bp_target_q <= '0;
    end else begin
      bp_en_q     <= br_hit;
      bp_dir_q    <= br_hit & bus.retire_taken[br_slot];
      bp_pc_q     <= br_hit ? bus.retire_pc[br_slot] : '0;
      bp_target_q <= br_hit ? bp_target_d : '0;
    end
  end

`ifdef RECOVERY_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mispredict_count <= 16'd0;
    end else if ((state_q == IDLE) && mis_hit && (mispredict_count != 16'hFFFF)) begin
      mispredict_count <= mispredict_count + 16'd1;
    end
  end
`endif

  assign bus.commit_mask       = commit_mask;
  assign bus.recover_en        = recover_en;
  assign bus.dispatch_stall    = dispatch_stall;
  assign bus.fetch_redirect_en = redirect_en;
  assign bus.fetch_redirect_pc = redirect_en ? redirect_pc_q : '0;
  assign bus.bp_update_en      = bp_en_q;
  assign bus.bp_update_pc      = bp_pc_q;
  assign bus.bp_update_dir     = bp_dir_q;
  assign bus.bp_update_target  = bp_target_q;

endmodule

// File: tb/tb_recovery_ctrl.sv
// Self-checking bench for recovery_ctrl: vector table, recovery corner sequences, random vs. cycle-level model.
module tb_recovery_ctrl;
  localparam int XLEN      = 32;
  localparam int DRAIN_MAX = 15;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  recovery_ctrl_if #(.XLEN(XLEN)) bus ();
`ifdef RECOVERY_STATS_EN
  logic [15:0] mispredict_count;
`endif

  recovery_ctrl #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef RECOVERY_STATS_EN
    ,
    .mispredict_count (mispredict_count)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;
  int exp_mp = 0;

  typedef struct {
    logic [2:0]           valid, need, br, taken;
    logic [2:0][XLEN-1:0] pc, tgt;
    logic [2:0]           exp_mask;
    logic                 exp_bp_en, exp_dir;
    logic [XLEN-1:0]      exp_bp_pc, exp_bp_tgt;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.retire_valid        = 3'b000;
    bus.retire_precise_need = 3'b000;
    bus.retire_is_branch    = 3'b000;
    bus.retire_taken        = 3'b000;
    bus.retire_pc           = '0;
    bus.retire_target_pc    = '0;
    bus.sq_empty            = 1'b1;
    bus.fu_busy             = 1'b0;
  endtask

  task automatic drive_mis(input logic [1:0] slot, input logic [XLEN-1:0] tgt, input logic sq);
    drive_idle();
    bus.retire_valid[slot]        = 1'b1;
    bus.retire_precise_need[slot] = 1'b1;
    bus.retire_target_pc[slot]    = tgt;
    bus.sq_empty                  = sq;
  endtask

  // Committed slots: every valid slot from oldest down to the first one needing recovery.
  function automatic logic [2:0] ref_mask(input logic [2:0] v, input logic [2:0] n);
    logic [2:0] m;
    bit stop;
    m = 3'b000;
    stop = 0;
    for (int i = 2; i >= 0; i--) begin
      if (!stop && v[i]) begin
        m[i] = 1'b1;
        if (n[i]) stop = 1;
      end
    end
    return m;
  endfunction

  task automatic ref_bp(input logic [2:0] m, input logic [2:0] br, input logic [2:0] tk,
                        input logic [2:0][XLEN-1:0] pc, input logic [2:0][XLEN-1:0] tgt,
                        output logic en, output logic dir,
                        output logic [XLEN-1:0] bpc, output logic [XLEN-1:0] btgt);
    en = 0; dir = 0; bpc = '0; btgt = '0;
    for (int i = 2; i >= 0; i--) begin
      if (!en && m[i] && br[i]) begin
        en   = 1;
        dir  = tk[i];
        bpc  = pc[i];
        btgt = tk[i] ? tgt[i] : pc[i] + 4;
      end
    end
  endtask

  initial begin
    vt[0] = '{valid:3'b111, need:3'b000, br:3'b010, taken:3'b010,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h0, 32'h100, 32'h0},
              exp_mask:3'b111, exp_bp_en:1, exp_dir:1, exp_bp_pc:32'h14, exp_bp_tgt:32'h100};
    vt[1] = '{valid:3'b111, need:3'b100, br:3'b000, taken:3'b000,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h40, 32'h0, 32'h0},
              exp_mask:3'b100, exp_bp_en:0, exp_dir:0, exp_bp_pc:32'h0, exp_bp_tgt:32'h0};
    vt[2] = '{valid:3'b111, need:3'b010, br:3'b001, taken:3'b001,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h0, 32'h2000, 32'h300},
              exp_mask:3'b110, exp_bp_en:0, exp_dir:0, exp_bp_pc:32'h0, exp_bp_tgt:32'h0};
    vt[3] = '{valid:3'b101, need:3'b010, br:3'b000, taken:3'b000,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h0, 32'h2000, 32'h0},
              exp_mask:3'b101, exp_bp_en:0, exp_dir:0, exp_bp_pc:32'h0, exp_bp_tgt:32'h0};
    vt[4] = '{valid:3'b011, need:3'b000, br:3'b001, taken:3'b000,
              pc:{32'h0, 32'h20, 32'hFFFF_FFFC}, tgt:{32'h0, 32'h0, 32'h1234},
              exp_mask:3'b011, exp_bp_en:1, exp_dir:0, exp_bp_pc:32'hFFFF_FFFC, exp_bp_tgt:32'h0};
    vt[5] = '{valid:3'b111, need:3'b000, br:3'b011, taken:3'b001,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h0, 32'h500, 32'h600},
              exp_mask:3'b111, exp_bp_en:1, exp_dir:0, exp_bp_pc:32'h14, exp_bp_tgt:32'h18};
    vt[6] = '{valid:3'b111, need:3'b001, br:3'b100, taken:3'b100,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h700, 32'h0, 32'h800},
              exp_mask:3'b111, exp_bp_en:1, exp_dir:1, exp_bp_pc:32'h10, exp_bp_tgt:32'h700};
    vt[7] = '{valid:3'b000, need:3'b111, br:3'b111, taken:3'b111,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h1, 32'h2, 32'h3},
              exp_mask:3'b000, exp_bp_en:0, exp_dir:0, exp_bp_pc:32'h0, exp_bp_tgt:32'h0};
    vt[8] = '{valid:3'b110, need:3'b100, br:3'b100, taken:3'b000,
              pc:{32'hFFFF_FFF0, 32'h14, 32'h18}, tgt:{32'h900, 32'h0, 32'h0},
              exp_mask:3'b100, exp_bp_en:1, exp_dir:0, exp_bp_pc:32'hFFFF_FFF0, exp_bp_tgt:32'hFFFF_FFF4};
    vt[9] = '{valid:3'b010, need:3'b000, br:3'b010, taken:3'b010,
              pc:{32'h10, 32'h14, 32'h18}, tgt:{32'h0, 32'hABC0, 32'h0},
              exp_mask:3'b010, exp_bp_en:1, exp_dir:1, exp_bp_pc:32'h14, exp_bp_tgt:32'hABC0};
  end

  initial begin
    int drain_n, stall_low, red_seen, rec_seen;
    drive_idle();
    reset = 1'b0;
    #12;
    chk("rst_mask",   bus.commit_mask, 3'b000);
    chk("rst_rec",    bus.recover_en, 1'b0);
    chk("rst_stall",  bus.dispatch_stall, 1'b0);
    chk("rst_red_en", bus.fetch_redirect_en, 1'b0);
    chk("rst_red_pc", bus.fetch_redirect_pc, 32'h0);
    chk("rst_bp_en",  bus.bp_update_en, 1'b0);
`ifdef RECOVERY_STATS_EN
    chk("rst_mp_cnt", mispredict_count, 16'd0);
`endif
    cyc();
    reset = 1'b1;
    cyc();

    // Table vectors, each followed by enough idle cycles for any recovery to complete.
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.retire_valid        = vt[k].valid;
      bus.retire_precise_need = vt[k].need;
      bus.retire_is_branch    = vt[k].br;
      bus.retire_taken        = vt[k].taken;
      bus.retire_pc           = vt[k].pc;
      bus.retire_target_pc    = vt[k].tgt;
      @(negedge clock);
      chk($sformatf("vec%0d_mask", k), bus.commit_mask, vt[k].exp_mask);
      cyc();
      drive_idle();
      @(negedge clock);
      chk($sformatf("vec%0d_bp_en", k), bus.bp_update_en, vt[k].exp_bp_en);
      if (vt[k].exp_bp_en) begin
        chk($sformatf("vec%0d_bp_dir", k), bus.bp_update_dir, vt[k].exp_dir);
        chk($sformatf("vec%0d_bp_pc", k),  bus.bp_update_pc, vt[k].exp_bp_pc);
        chk($sformatf("vec%0d_bp_tgt", k), bus.bp_update_target, vt[k].exp_bp_tgt);
      end
      for (int j = 0; j < 4; j++) cyc();
    end

    // Minimum-latency recovery from slot 1.
    cyc();
    drive_idle();
    bus.retire_valid         = 3'b111;
    bus.retire_precise_need  = 3'b010;
    bus.retire_target_pc[1]  = 32'h2000;
    @(negedge clock);
    chk("lat_mask", bus.commit_mask, 3'b110);
    cyc(); drive_idle(); @(negedge clock);
    chk("lat_n1_rec", bus.recover_en, 1'b1);
    chk("lat_n1_stall", bus.dispatch_stall, 1'b1);
    chk("lat_n1_red", bus.fetch_redirect_en, 1'b0);
    cyc(); @(negedge clock);
    chk("lat_n2_rec", bus.recover_en, 1'b0);
    chk("lat_n2_stall", bus.dispatch_stall, 1'b1);
    chk("lat_n2_red", bus.fetch_redirect_en, 1'b0);
    cyc(); @(negedge clock);
    chk("lat_n3_red", bus.fetch_redirect_en, 1'b1);
    chk("lat_n3_pc", bus.fetch_redirect_pc, 32'h2000);
    chk("lat_n3_stall", bus.dispatch_stall, 1'b1);
    cyc(); @(negedge clock);
    chk("lat_n4_red", bus.fetch_redirect_en, 1'b0);
    chk("lat_n4_pc", bus.fetch_redirect_pc, 32'h0);
    chk("lat_n4_stall", bus.dispatch_stall, 1'b0);
    exp_mp++;

    // Drain timeout with store queue never empty.
    cyc();
    drive_mis(2'd2, 32'h3000, 1'b0);
    cyc(); drive_idle(); bus.sq_empty = 1'b0;
    drain_n = 0; stall_low = 0; red_seen = 0;
    for (int j = 0; j < 40; j++) begin
      cyc(); @(negedge clock);
      if (bus.fetch_redirect_en) begin
        red_seen = 1;
        break;
      end
      drain_n++;
      if (!bus.dispatch_stall) stall_low++;
    end
    chk("to_drain_cycles", drain_n, 15);
    chk("to_stall_low", stall_low, 0);
    chk("to_red_seen", red_seen, 1);
    chk("to_red_pc", bus.fetch_redirect_pc, 32'h3000);
    exp_mp++;
    cyc(); cyc();

    // Mispredict arriving during DRAIN is ignored.
    cyc();
    drive_mis(2'd0, 32'h4444, 1'b0);
    cyc(); drive_idle(); bus.sq_empty = 1'b0;
    cyc();
    bus.retire_valid = 3'b111; bus.retire_precise_need = 3'b100;
    bus.retire_target_pc[2] = 32'h9999;
    @(negedge clock);
    chk("nest_mask", bus.commit_mask, 3'b000);
    rec_seen = 0;
    for (int j = 0; j < 3; j++) begin
      cyc(); @(negedge clock);
      if (bus.recover_en) rec_seen++;
    end
    drive_idle();
    red_seen = 0;
    for (int j = 0; j < 20; j++) begin
      cyc(); @(negedge clock);
      if (bus.recover_en) rec_seen++;
      if (bus.fetch_redirect_en) begin
        red_seen = 1;
        break;
      end
    end
    chk("nest_red_seen", red_seen, 1);
    chk("nest_red_pc", bus.fetch_redirect_pc, 32'h4444);
    chk("nest_rec_count", rec_seen, 0);
    exp_mp++;
    cyc(); cyc();

    // Reset during DRAIN abandons the recovery.
    cyc();
    drive_mis(2'd1, 32'h5550, 1'b0);
    bus.retire_is_branch[1] = 1'b1;
    cyc(); drive_idle(); bus.sq_empty = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("mrst_stall", bus.dispatch_stall, 1'b0);
    chk("mrst_red_en", bus.fetch_redirect_en, 1'b0);
    chk("mrst_rec", bus.recover_en, 1'b0);
    chk("mrst_bp_en", bus.bp_update_en, 1'b0);
`ifdef RECOVERY_STATS_EN
    chk("mrst_mp_cnt", mispredict_count, 16'd0);
`endif
    exp_mp = 0;
    cyc(); cyc();
    reset = 1'b1;
    bus.sq_empty = 1'b1;
    red_seen = 0; stall_low = 0;
    for (int j = 0; j < 20; j++) begin
      cyc(); @(negedge clock);
      if (bus.fetch_redirect_en) red_seen++;
      if (bus.dispatch_stall) stall_low++;
    end
    chk("mrst_no_redirect", red_seen, 0);
    chk("mrst_no_stall", stall_low, 0);

`ifdef RECOVERY_STATS_EN
    for (int r = 0; r < 3; r++) begin
      cyc();
      drive_mis(2'(r), 32'h100 * (r + 1), 1'b1);
      cyc(); drive_idle();
      for (int j = 0; j < 4; j++) cyc();
    end
    @(negedge clock);
    chk("stats_three", mispredict_count, 16'd3);
    exp_mp = 3;
`endif

    // Random traffic against a cycle-numbered model of the recovery timeline.
    begin
      bit act;
      int fl, rd;
      logic [XLEN-1:0] rpc;
      logic [2:0] m;
      logic pbp_en, pbp_dir, nbp_en, nbp_dir;
      logic [XLEN-1:0] pbp_pc, pbp_tgt, nbp_pc, nbp_tgt;
      act = 0; fl = -1; rd = -1; rpc = '0;
      pbp_en = 0; pbp_dir = 0; pbp_pc = '0; pbp_tgt = '0;
      for (int t = 0; t < 2000; t++) begin
        cyc();
        bus.retire_valid = 3'($urandom);
        for (int i = 0; i < 3; i++) begin
          bus.retire_precise_need[i] = ($urandom_range(0, 7) == 0);
          bus.retire_pc[i]           = $urandom;
          bus.retire_target_pc[i]    = $urandom;
        end
        bus.retire_is_branch = 3'($urandom);
        bus.retire_taken     = 3'($urandom);
        bus.sq_empty         = ($urandom_range(0, 5) == 0);
        bus.fu_busy          = ($urandom_range(0, 2) == 0);
        @(negedge clock);
        m = act ? 3'b000 : ref_mask(bus.retire_valid, bus.retire_precise_need);
        chk("rnd_mask",  bus.commit_mask, m);
        chk("rnd_rec",   bus.recover_en, act && (t == fl));
        chk("rnd_stall", bus.dispatch_stall, act);
        chk("rnd_red_en", bus.fetch_redirect_en, act && (t == rd));
        chk("rnd_red_pc", bus.fetch_redirect_pc, (act && (t == rd)) ? rpc : '0);
        chk("rnd_bp_en", bus.bp_update_en, pbp_en);
        if (pbp_en) begin
          chk("rnd_bp_pc",  bus.bp_update_pc, pbp_pc);
          chk("rnd_bp_dir", bus.bp_update_dir, pbp_dir);
          chk("rnd_bp_tgt", bus.bp_update_target, pbp_tgt);
        end
        ref_bp(m, bus.retire_is_branch, bus.retire_taken, bus.retire_pc, bus.retire_target_pc,
               nbp_en, nbp_dir, nbp_pc, nbp_tgt);
        pbp_en = nbp_en; pbp_dir = nbp_dir; pbp_pc = nbp_pc; pbp_tgt = nbp_tgt;
        if (!act) begin
          if ((m & bus.retire_precise_need) != 3'b000) begin
            act = 1; fl = t + 1; rd = -1;
            for (int i = 2; i >= 0; i--)
              if (m[i] && bus.retire_precise_need[i]) rpc = bus.retire_target_pc[i];
            exp_mp++;
          end
        end else if (t == rd) begin
          act = 0;
        end else if ((t > fl) && (rd < 0)) begin
          if ((bus.sq_empty && !bus.fu_busy) || ((t - fl) == DRAIN_MAX)) rd = t + 1;
        end
      end
    end

`ifdef RECOVERY_STATS_EN
    @(negedge clock);
    chk("stats_final", mispredict_count, 16'(exp_mp));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
